// File: rtl/pattern_waveform_gen.sv
// Serial waveform generator: latches a pattern on start and shifts it out MSB-first,
// repeating it a programmable number of times with a start/busy/done handshake.
module pattern_waveform_gen #(
   parameter int WIDTH = 8,
   parameter int CW    = 3,
   parameter int RW    = 4
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [WIDTH-1:0] pattern,
   input  logic [RW-1:0]    repeats,
   input  logic             hold,
   output logic             wave_out,
   output logic [CW-1:0]    phase,
   output logic             busy,
   output logic             done
);

   localparam logic [CW-1:0] LAST_PHASE = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shadow;
   logic [RW-1:0]    rep_left;
   logic [CW-1:0]    phase_dec;

   assign phase_dec = phase - CW'(1);

   // The phase counter counts down; the wrap at zero is an explicit reload so a
   // new period starts on the very next edge with no gap.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state    <= IDLE;
         wave_out <= 1'b0;
         phase    <= LAST_PHASE;
         busy     <= 1'b0;
         done     <= 1'b0;
         shadow   <= '0;
         rep_left <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               wave_out <= 1'b0;
               busy     <= 1'b0;
               phase    <= LAST_PHASE;
               if (start) begin
                  shadow   <= pattern;
                  rep_left <= repeats;
                  wave_out <= pattern[WIDTH-1];
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               // hold freezes everything, including the wrap and the completion step
               if (!hold) begin
                  if (phase != '0) begin
                     phase    <= phase_dec;
                     wave_out <= shadow[phase_dec];
                  end else if (rep_left != '0) begin
                     rep_left <= rep_left - RW'(1);
                     phase    <= LAST_PHASE;
                     wave_out <= shadow[WIDTH-1];
                  end else begin
                     state    <= IDLE;
                     busy     <= 1'b0;
                     wave_out <= 1'b0;
                     phase    <= LAST_PHASE;
                     done     <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_waveform_gen.sv
// Self-checking bench for pattern_waveform_gen: expected waveforms are built as a list of
// (bit, phase) entries from the pattern and repeat count, stretched by the hold decisions.
module tb_pattern_waveform_gen;

   logic       clock = 1'b0;
   logic       clear;
   logic       start;
   logic [7:0] pattern;
   logic [3:0] repeats;
   logic       hold;
   logic       wave_out;
   logic [2:0] phase;
   logic       busy;
   logic       done;

   int compared   = 0;
   int mismatched = 0;

   pattern_waveform_gen #(.WIDTH(8), .CW(3), .RW(4)) dut (
      .clock   (clock),
      .clear   (clear),
      .start   (start),
      .pattern (pattern),
      .repeats (repeats),
      .hold    (hold),
      .wave_out(wave_out),
      .phase   (phase),
      .busy    (busy),
      .done    (done)
   );

   always #5 clock = ~clock;

   // Starts a run in the current cycle and follows it to the done pulse.
   task automatic run_check(input string name, input logic [7:0] pat, input logic [3:0] rep,
                            input int hold_pct, input int hold_phase, input int hold_len,
                            input bit noise, input bit check_idle);
      logic [3:0] q[$];
      logic [5:0] expv;
      logic [5:0] got;
      int idx = 0;
      int iter = 0;
      int holds = 0;
      int targeted = 0;
      int busy_cnt = 0;
      bit h;
      for (int p = 0; p <= int'(rep); p++)
         for (int i = 7; i >= 0; i--)
            q.push_back({pat[i], 3'(i)});
      start   = 1'b1;
      pattern = pat;
      repeats = rep;
      hold    = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      start = 1'b0;
      hold  = 1'b0;
      while (idx < q.size() && iter < 1000) begin
         expv = {q[idx][3], q[idx][2:0], 1'b1, 1'b0};
         got  = {wave_out, phase, busy, done};
         compared++;
         if (got !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s cycle %0d: wave/phase/busy/done got %b expected %b", name, iter, got, expv);
         end
         if (busy === 1'b1) busy_cnt++;
         h = 1'b0;
         if (hold_phase >= 0 && int'(q[idx][2:0]) == hold_phase && targeted < hold_len) begin
            h = 1'b1;
            targeted++;
         end else if (hold_pct > 0 && int'($urandom_range(0, 99)) < hold_pct) begin
            h = 1'b1;
         end
         if (h) holds++;
         hold = h;
         if (noise) begin
            start   = 1'($urandom_range(0, 1));
            pattern = 8'($urandom);
            repeats = 4'($urandom);
         end
         @(posedge clock); #1;
         if (!h) idx++;
         iter++;
      end
      hold  = 1'b0;
      start = 1'b0;
      if (iter >= 1000) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL %s timeout: got %0d cycles required completion", name, iter);
      end
      expv = {1'b0, 3'd7, 1'b0, 1'b1};
      got  = {wave_out, phase, busy, done};
      compared++;
      if (got !== expv) begin
         mismatched++;
         $display("[TB] FAIL %s done cycle: wave/phase/busy/done got %b expected %b", name, got, expv);
      end
      compared++;
      if (busy_cnt != q.size() + holds) begin
         mismatched++;
         $display("[TB] FAIL %s busy length: got %0d expected %0d", name, busy_cnt, q.size() + holds);
      end
      if (check_idle) begin
         hold = 1'($urandom_range(0, 1));
         @(posedge clock); #1;
         hold = 1'b0;
         expv = {1'b0, 3'd7, 1'b0, 1'b0};
         got  = {wave_out, phase, busy, done};
         compared++;
         if (got !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s idle after done: got %b expected %b", name, got, expv);
         end
      end
   endtask

   task automatic test_reset();
      logic [5:0] got;
      clear = 1'b0;
      start = 1'b0;
      pattern = 8'hFF;
      repeats = 4'h0;
      hold = 1'b0;
      #12;
      got = {wave_out, phase, busy, done};
      compared++;
      if (got !== 6'b0_111_0_0) begin
         mismatched++;
         $display("[TB] FAIL reset values: got %b expected %b", got, 6'b0_111_0_0);
      end
      @(negedge clock);
      clear = 1'b1;
      @(posedge clock); #1;
      got = {wave_out, phase, busy, done};
      compared++;
      if (got !== 6'b0_111_0_0) begin
         mismatched++;
         $display("[TB] FAIL idle after reset: got %b expected %b", got, 6'b0_111_0_0);
      end
   endtask

   task automatic test_basic();
      run_check("basic_B2", 8'b1011_0010, 4'd0, 0, -1, 0, 1'b0, 1'b1);
   endtask

   task automatic test_repeats();
      run_check("repeats_F0", 8'hF0, 4'd2, 0, -1, 0, 1'b0, 1'b1);
      run_check("max_repeats", 8'($urandom), 4'd15, 10, -1, 0, 1'b0, 1'b1);
   endtask

   task automatic test_hold();
      run_check("hold_A5", 8'hA5, 4'd0, 0, 4, 3, 1'b0, 1'b1);
      run_check("hold_at_zero", 8'h3C, 4'd1, 0, 0, 2, 1'b0, 1'b1);
   endtask

   task automatic test_ignored_inputs();
      run_check("ignored_C3", 8'hC3, 4'd0, 0, -1, 0, 1'b1, 1'b1);
   endtask

   task automatic test_back_to_back();
      run_check("b2b_first", 8'h5E, 4'd0, 0, -1, 0, 1'b0, 1'b0);
      run_check("b2b_81", 8'h81, 4'd0, 0, -1, 0, 1'b0, 1'b1);
   endtask

   task automatic test_async_reset();
      logic [5:0] got;
      start   = 1'b1;
      pattern = 8'h5A;
      repeats = 4'd1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (4) begin
         @(posedge clock); #1;
      end
      got = {wave_out, phase, busy, done};
      compared++;
      if (got !== 6'b1_011_1_0) begin
         mismatched++;
         $display("[TB] FAIL pre-reset phase3: got %b expected %b", got, 6'b1_011_1_0);
      end
      #2 clear = 1'b0;
      #1;
      got = {wave_out, phase, busy, done};
      compared++;
      if (got !== 6'b0_111_0_0) begin
         mismatched++;
         $display("[TB] FAIL async reset mid-run: got %b expected %b", got, 6'b0_111_0_0);
      end
      @(negedge clock);
      clear = 1'b1;
      for (int c = 0; c < 3; c++) begin
         hold = 1'($urandom_range(0, 1));
         @(posedge clock); #1;
         got = {wave_out, phase, busy, done};
         compared++;
         if (got !== 6'b0_111_0_0) begin
            mismatched++;
            $display("[TB] FAIL idle after async reset cycle %0d: got %b expected %b", c, got, 6'b0_111_0_0);
         end
      end
      hold = 1'b0;
      run_check("after_reset", 8'h6D, 4'd0, 0, -1, 0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 12; n++) begin
         run_check($sformatf("random_%0d", n), 8'($urandom), 4'($urandom_range(0, 3)),
                   20, -1, 0, 1'b1, 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_repeats();
      test_hold();
      test_ignored_inputs();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
